// File: rtl/uart_msg_streamer.sv
// uart_msg_streamer: streams a message held in a writable buffer into a uart_tx
// using its strobe/busy handshake, with one-shot or repeat mode and an idle gap
// between repeats.
//
// Ports:
//   i_clock, i_reset_n      clock (rising edge), async active-low reset
//   i_wr_en/addr/data       synchronous buffer write port, accepted in any state
//   i_len                   message length 0..DEPTH (larger values clamp), sampled at start
//   i_start                 start pulse, honoured only in IDLE
//   i_repeat                loop the message; sampled at the end of each pass
//   i_stop                  graceful abort; the in-flight byte always completes
//   i_busy                  uart_tx busy
//   o_data, o_act           byte and one-cycle send strobe to uart_tx
//   o_active                high whenever the streamer is not IDLE
//   o_done                  one-cycle pulse when streaming finishes
module uart_msg_streamer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned GAP_CYCLES = 1000,
    parameter int unsigned GAP_WIDTH  = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH:0]   i_len,
    input  logic                  i_start,
    input  logic                  i_repeat,
    input  logic                  i_stop,
    input  logic                  i_busy,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_act,
    output logic                  o_active,
    output logic                  o_done
);

    localparam int unsigned LEN_WIDTH = ADDR_WIDTH + 1;
    localparam logic [LEN_WIDTH-1:0] LP_DEPTH    = LEN_WIDTH'(DEPTH);
    localparam logic [GAP_WIDTH-1:0] LP_GAP_LAST =
        GAP_WIDTH'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_WAIT_HI,
        S_WAIT_LO,
        S_GAP,
        S_DONE
    } state_t;

    state_t                r_state, w_next_state;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0] r_index, w_index_nxt;
    logic [LEN_WIDTH-1:0]  r_len, w_len_nxt;
    logic [GAP_WIDTH-1:0]  r_gap, w_gap_nxt;
    logic                  r_stop_pend, w_stop_pend_nxt;
    logic                  r_act, w_act_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_active;
    logic                  w_load_data;
    logic                  w_rd_en;
    logic                  w_stop;
    logic                  w_last;

    // A stop seen this cycle counts as pending so the exit decision never lags it.
    assign w_stop = r_stop_pend | i_stop;
    assign w_last = ({1'b0, r_index} == (r_len - LEN_WIDTH'(1)));

    // Message buffer: not reset; read issued in FETCH, data valid in SEND.
    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (w_rd_en) begin
            r_rd_data <= r_mem[r_index];
        end
    end

    // State register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        w_next_state    = r_state;
        w_index_nxt     = r_index;
        w_len_nxt       = r_len;
        w_gap_nxt       = r_gap;
        w_stop_pend_nxt = r_stop_pend | (i_stop && (r_state != S_IDLE));
        w_act_nxt       = 1'b0;
        w_done_nxt      = 1'b0;
        w_load_data     = 1'b0;
        w_rd_en         = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Stop in IDLE is ignored, including when it coincides with start.
                w_stop_pend_nxt = 1'b0;
                if (i_start) begin
                    w_index_nxt = '0;
                    if (i_len == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_len_nxt    = (i_len > LP_DEPTH) ? LP_DEPTH : i_len;
                        w_next_state = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                w_rd_en      = 1'b1;
                w_next_state = S_SEND;
            end
            S_SEND: begin
                if (!i_busy) begin
                    w_load_data  = 1'b1;
                    w_act_nxt    = 1'b1;
                    w_next_state = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (i_busy) begin
                    w_next_state = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!i_busy) begin
                    if (w_stop) begin
                        w_next_state = S_DONE;
                    end else if (!w_last) begin
                        w_index_nxt  = r_index + ADDR_WIDTH'(1);
                        w_next_state = S_FETCH;
                    end else if (!i_repeat) begin
                        w_next_state = S_DONE;
                    end else if (GAP_CYCLES == 0) begin
                        w_index_nxt  = '0;
                        w_next_state = S_FETCH;
                    end else begin
                        w_gap_nxt    = '0;
                        w_next_state = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (w_stop) begin
                    w_next_state = S_DONE;
                end else if (r_gap == LP_GAP_LAST) begin
                    w_gap_nxt    = '0;
                    w_index_nxt  = '0;
                    w_next_state = S_FETCH;
                end else begin
                    w_gap_nxt = r_gap + GAP_WIDTH'(1);
                end
            end
            S_DONE: begin
                w_stop_pend_nxt = 1'b0;
                w_next_state    = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // o_done is registered, so it is high during the DONE cycle itself.
        if (w_next_state == S_DONE) begin
            w_done_nxt = 1'b1;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_index     <= '0;
            r_len       <= '0;
            r_gap       <= '0;
            r_stop_pend <= 1'b0;
            r_data      <= '0;
            r_act       <= 1'b0;
            r_done      <= 1'b0;
            r_active    <= 1'b0;
        end else begin
            r_index     <= w_index_nxt;
            r_len       <= w_len_nxt;
            r_gap       <= w_gap_nxt;
            r_stop_pend <= w_stop_pend_nxt;
            r_act       <= w_act_nxt;
            r_done      <= w_done_nxt;
            r_active    <= (w_next_state != S_IDLE);
            if (w_load_data) begin
                r_data <= r_rd_data;
            end
        end
    end

    assign o_data   = r_data;
    assign o_act    = r_act;
    assign o_active = r_active;
    assign o_done   = r_done;

endmodule

// File: tb/tb_uart_msg_streamer.sv
// Directed bench for uart_msg_streamer with a behavioural uart_tx busy model.
module tb_uart_msg_streamer;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned GAP   = 10;
    localparam int unsigned GW    = 16;
    localparam int          BUDGET = 3000;

    logic          i_clock = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          i_wr_en = 1'b0;
    logic [AW-1:0] i_wr_addr = '0;
    logic [DW-1:0] i_wr_data = '0;
    logic [AW:0]   i_len = '0;
    logic          i_start = 1'b0;
    logic          i_repeat = 1'b0;
    logic          i_stop = 1'b0;
    logic          i_busy = 1'b0;
    logic [DW-1:0] o_data;
    logic          o_act;
    logic          o_active;
    logic          o_done;

    uart_msg_streamer #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(AW),
        .GAP_CYCLES(GAP),
        .GAP_WIDTH (GW)
    ) dut (
        .i_clock  (i_clock),
        .i_reset_n(i_reset_n),
        .i_wr_en  (i_wr_en),
        .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data),
        .i_len    (i_len),
        .i_start  (i_start),
        .i_repeat (i_repeat),
        .i_stop   (i_stop),
        .i_busy   (i_busy),
        .o_data   (o_data),
        .o_act    (o_act),
        .o_active (o_active),
        .o_done   (o_done)
    );

    always #5 i_clock = ~i_clock;

    int nvec  = 0;
    int nfail = 0;
    int cyc   = 0;

    // Observation logs.
    logic [DW-1:0] act_q[$];
    int            act_cyc[$];
    int            fall_cyc[$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            viol = 0;
    int            start_cyc = 0;
    int            stop_cyc = 0;

    // uart model state.
    int   busy_cnt = 0;
    logic model_busy = 1'b0;
    logic force_busy = 1'b0;

    logic [DW-1:0] mem_m [DEPTH];

    typedef struct {
        logic [AW:0] len;
        int          exp_acts;
    } vec_t;
    vec_t vecs [6];

    always @(posedge i_clock) cyc++;

    // Monitor plus uart_tx model: busy rises one cycle after act, lasts 20 cycles.
    always @(negedge i_clock) begin
        if (o_act) begin
            act_q.push_back(o_data);
            act_cyc.push_back(cyc);
            if (i_busy) viol++;
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                model_busy = 1'b0;
                fall_cyc.push_back(cyc);
            end
        end
        if (o_act) begin
            model_busy = 1'b1;
            busy_cnt   = 20;
        end
        i_busy = model_busy | force_busy;
    end

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clock);
        #1;
    endtask

    task automatic clear_logs();
        act_q.delete();
        act_cyc.delete();
        fall_cyc.delete();
        done_cnt = 0;
        done_cyc = 0;
    endtask

    task automatic wr(input int addr, input logic [DW-1:0] data);
        i_wr_en   = 1'b1;
        i_wr_addr = AW'(addr);
        i_wr_data = data;
        tick(1);
        i_wr_en   = 1'b0;
    endtask

    task automatic pulse_start(input logic [AW:0] len);
        i_len     = len;
        i_start   = 1'b1;
        start_cyc = cyc;
        tick(1);
        i_start   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_cnt == 0 && n < BUDGET) begin
            tick(1);
            n++;
        end
        if (done_cnt == 0) begin
            nvec++;
            nfail++;
            $display("FAIL %s_timeout: got no o_done expected one within %0d cycles", name, BUDGET);
        end
    endtask

    // Polls just after the falling edge so stimulus can land in the same state.
    task automatic wait_acts(input string name, input int n);
        int k = 0;
        while (act_q.size() < n && k < BUDGET) begin
            @(negedge i_clock);
            #1;
            k++;
        end
        if (act_q.size() < n) begin
            nvec++;
            nfail++;
            $display("FAIL %s_act_timeout: got %0d acts expected %0d", name, act_q.size(), n);
        end
    endtask

    task automatic wait_falls(input string name, input int n);
        int k = 0;
        while (fall_cyc.size() < n && k < BUDGET) begin
            @(negedge i_clock);
            #1;
            k++;
        end
        if (fall_cyc.size() < n) begin
            nvec++;
            nfail++;
            $display("FAIL %s_fall_timeout: got %0d falls expected %0d", name, fall_cyc.size(), n);
        end
    endtask

    task automatic check_bytes(input string name, input int n, input int modulo);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_byte%0d", name, i),
                  (i < act_q.size()) ? int'(act_q[i]) : -1, int'(mem_m[i % modulo]));
        end
    endtask

    initial begin
        mem_m[0] = 8'h48; mem_m[1] = 8'h45; mem_m[2] = 8'h4C;
        mem_m[3] = 8'h4C; mem_m[4] = 8'h4F;
        for (int i = 5; i < DEPTH; i++) mem_m[i] = DW'(8'hA0 + i);

        vecs[0] = '{len: 5'd5,  exp_acts: 5};
        vecs[1] = '{len: 5'd0,  exp_acts: 0};
        vecs[2] = '{len: 5'd17, exp_acts: 16};
        vecs[3] = '{len: 5'd1,  exp_acts: 1};
        vecs[4] = '{len: 5'd16, exp_acts: 16};
        vecs[5] = '{len: 5'd3,  exp_acts: 3};

        // Reset state.
        tick(3);
        check("rst_o_data", int'(o_data), 0);
        check("rst_o_act", int'(o_act), 0);
        check("rst_o_active", int'(o_active), 0);
        check("rst_o_done", int'(o_done), 0);
        i_reset_n = 1'b1;
        tick(2);

        for (int i = 0; i < DEPTH; i++) wr(i, mem_m[i]);
        tick(2);

        // One-shot messages from the vector table.
        foreach (vecs[k]) begin
            clear_logs();
            i_repeat = 1'b0;
            pulse_start(vecs[k].len);
            wait_done($sformatf("v%0d", k));
            tick(3);
            check($sformatf("v%0d_acts", k), act_q.size(), vecs[k].exp_acts);
            check_bytes($sformatf("v%0d", k), vecs[k].exp_acts, DEPTH);
            check($sformatf("v%0d_done_cnt", k), done_cnt, 1);
            check($sformatf("v%0d_active_end", k), int'(o_active), 0);
            if (vecs[k].len == '0) begin
                check($sformatf("v%0d_done_latency", k), done_cyc - start_cyc, 1);
            end
        end

        // Repeat with gap; repeat cleared during pass 2.
        clear_logs();
        i_repeat = 1'b1;
        pulse_start(5'd3);
        wait_acts("rep", 4);
        i_repeat = 1'b0;
        wait_done("rep");
        tick(3);
        check("rep_acts", act_q.size(), 6);
        check_bytes("rep", 6, 3);
        check("rep_done_cnt", done_cnt, 1);
        check("rep_gap_ge12",
              (act_cyc.size() > 3 && fall_cyc.size() > 2) ? int'((act_cyc[3] - fall_cyc[2]) >= 12) : 0, 1);

        // Stop during WAIT_HI of byte 1.
        clear_logs();
        pulse_start(5'd5);
        wait_acts("stophi", 2);
        i_stop = 1'b1;
        tick(1);
        i_stop = 1'b0;
        wait_done("stophi");
        tick(3);
        check("stophi_acts", act_q.size(), 2);
        check("stophi_done_cnt", done_cnt, 1);
        check("stophi_done_after_fall",
              (fall_cyc.size() > 1) ? int'(done_cyc > fall_cyc[1]) : 0, 1);

        // Stop during GAP.
        clear_logs();
        i_repeat = 1'b1;
        pulse_start(5'd2);
        wait_falls("stopgap", 2);
        tick(2);
        i_stop   = 1'b1;
        stop_cyc = cyc;
        tick(1);
        i_stop   = 1'b0;
        i_repeat = 1'b0;
        wait_done("stopgap");
        tick(3);
        check("stopgap_acts", act_q.size(), 2);
        check("stopgap_done_latency", done_cyc - stop_cyc, 1);
        check("stopgap_done_cnt", done_cnt, 1);

        // Busy held externally before start; a second start while active is ignored.
        force_busy = 1'b1;
        tick(2);
        clear_logs();
        pulse_start(5'd2);
        tick(30);
        check("hold_acts", act_q.size(), 0);
        check("hold_active", int'(o_active), 1);
        force_busy = 1'b0;
        wait_acts("hold", 1);
        pulse_start(5'd5);
        wait_done("hold");
        tick(3);
        check("hold_acts_final", act_q.size(), 2);
        check("hold_done_cnt", done_cnt, 1);

        // Reset in WAIT_LO, then buffer retained and streaming restarts at index 0.
        clear_logs();
        pulse_start(5'd5);
        wait_acts("rst", 1);
        tick(5);
        i_reset_n = 1'b0;
        #1;
        check("rst_mid_o_act", int'(o_act), 0);
        check("rst_mid_o_active", int'(o_active), 0);
        check("rst_mid_o_done", int'(o_done), 0);
        tick(2);
        i_reset_n = 1'b1;
        for (int k = 0; k < 50 && i_busy; k++) tick(1);
        tick(2);
        clear_logs();
        pulse_start(5'd5);
        wait_done("rst2");
        tick(3);
        check("rst2_acts", act_q.size(), 5);
        check_bytes("rst2", 5, DEPTH);

        check("act_while_busy", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/uart_msg_streamer.md
Name: uart_msg_streamer

Overview:
Parametrised successor to the fixed ROM-to-UART string sender. It holds a message in an internal writable buffer and streams it byte-by-byte into a UART transmitter using that transmitter's strobe/busy handshake. Message length, one-shot or repeat mode, and the inter-message gap are all configurable. It sits between a host or loader and the uart_tx instance.

Parameters:
DATA_WIDTH, 8, width of each message symbol
DEPTH, 16, message buffer entries; power of two
ADDR_WIDTH, 4, log2(DEPTH)
GAP_CYCLES, 1000, idle clocks between repeats (0 allowed)
GAP_WIDTH, 16, gap counter width; must hold GAP_CYCLES

Ports:
i_clock  in  1  single system clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_wr_en  in  1  buffer write strobe
i_wr_addr  in  ADDR_WIDTH  buffer write address
i_wr_data  in  DATA_WIDTH  buffer write data
i_len  in  ADDR_WIDTH+1  message length 0..DEPTH, sampled at start
i_start  in  1  start pulse, honoured only in IDLE
i_repeat  in  1  1 = loop message; sampled at end of each pass
i_stop  in  1  graceful abort request
i_busy  in  1  uart_tx busy
o_data  out  DATA_WIDTH  byte to uart_tx, stable from o_act until busy falls
o_act  out  1  one-cycle send strobe to uart_tx
o_active  out  1  high whenever state != IDLE
o_done  out  1  one-cycle pulse when streaming finishes

Behaviour:
- Reset (async assert, sync release): state IDLE, o_data=0, o_act=0, o_active=0, o_done=0, index=0, gap counter=0. Buffer contents not reset.
- Writes: synchronous, accepted in any state. A write to an entry not yet read affects the current pass.
- Buffer read is synchronous with 1-cycle latency.
- States:
  - IDLE: on i_start, latch len=i_len and index=0.
    - len=0: pulse o_done the next cycle, stay IDLE, no o_act.
    - len>DEPTH: clamp to DEPTH.
    - Otherwise go to FETCH.
  - FETCH: issue read of buffer[index], go to SEND.
  - SEND: register o_data = read data; o_act=1 for exactly this cycle if i_busy=0, then go to WAIT_HI. If i_busy=1, hold o_act=0 and wait in SEND.
  - WAIT_HI: wait for i_busy=1. uart_tx raises busy within 1 cycle of act.
  - WAIT_LO: wait for i_busy=0.
    - If index==len-1: go to GAP when i_repeat=1 and no stop is pending; otherwise go to DONE.
    - Else: index+1, go to FETCH.
  - GAP: count GAP_CYCLES clocks, then index=0 and go to FETCH. GAP_CYCLES=0 goes straight to FETCH. If i_stop arrives during GAP, go to DONE at once.
  - DONE: o_done=1 for one cycle, then IDLE.
- i_stop: latched as stop-pending in any non-IDLE state. The in-flight byte always completes: the block never drops o_act once issued and never abandons a byte awaiting busy. Exit is via DONE after WAIT_LO.
- i_start outside IDLE is ignored. i_start and i_stop in the same IDLE cycle: start wins, stop is ignored.
- Per-byte throughput: 3 cycles of overhead plus the UART frame time.
- o_act is never asserted while i_busy=1.
- o_data only changes in SEND.

Test Plan:
1. Load "HELLO" (0x48,0x45,0x4C,0x4C,0x4F) at addr 0-4, i_len=5, i_repeat=0, pulse i_start; model uart busy for 20 cycles per act -> exactly 5 o_act pulses carrying those bytes in order, then one o_done, then o_active=0.
2. i_len=3, i_repeat=1, GAP_CYCLES=10 -> bytes repeat 0,1,2,0,1,2; between the last busy fall and the next o_act there are ≥10+2 cycles. Clear i_repeat mid-pass 2 -> pass 2 finishes, then o_done.
3. i_stop pulsed during WAIT_HI of byte 1 of 5 -> byte 1 completes, no further o_act, o_done pulses after busy falls. i_stop during GAP -> o_done next cycle.
4. i_len=0 with i_start -> o_done pulse, zero o_act. i_len=17 with DEPTH=16 -> exactly 16 bytes sent.
5. Hold i_busy=1 externally before start -> o_act stays 0 in SEND until busy drops. i_start pulsed while active -> no effect on byte count.
6. Assert i_reset_n=0 mid-WAIT_LO -> o_act, o_active, o_done go 0 immediately. After release, a new start sends from index 0; buffer contents are retained.
